// File: rtl/logic_seq_ctrl_pkg.sv
// Shared definitions for the serial pattern-detector controller.
//   state_t   : controller state encoding
//   DEF_*     : default parameter values
//   len_mask  : pattern length -> low-order bit mask (MASK_W wide)
package logic_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_LEN_W   = 4;
    localparam int DEF_WIN_W   = 16;
    localparam int DEF_CNT_W   = 8;

    // Widest pattern supported; callers zero-extend narrower operands.
    localparam int MASK_W = 16;

    function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/logic_seq_match.sv
// History shift register, fill counter and masked pattern compare.
//   iCLK, iRST     : clock, synchronous active-low reset
//   iCLR           : clear history/fill/match at the start of a run
//   iIN, iIN_VALID : serial bit and its qualifier (already gated to RUN)
//   iPATTERN, iLEN : pattern (bit 0 = newest) and its length
//   oHIT           : combinational, accepted bit completes a match
//   oMATCH         : registered one-cycle match pulse
module logic_seq_match
    import logic_seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCLR,
    input  logic               iIN,
    input  logic               iIN_VALID,
    input  logic [MAX_LEN-1:0] iPATTERN,
    input  logic [LEN_W-1:0]   iLEN,
    output logic               oHIT,
    output logic               oMATCH
);

    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match;

    logic [MAX_LEN-1:0] w_hist_nxt;
    logic [LEN_W-1:0]   w_fill_nxt;
    logic [MASK_W-1:0]  w_mask;
    logic [MASK_W-1:0]  w_diff;

    assign w_hist_nxt = {r_hist[MAX_LEN-2:0], iIN};
    assign w_fill_nxt = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : r_fill + LEN_W'(1);
    assign w_mask     = len_mask(32'(iLEN));
    // Compare on the post-shift history so the bit being accepted counts.
    assign w_diff     = (MASK_W'(w_hist_nxt) ^ MASK_W'(iPATTERN)) & w_mask;
    assign oHIT       = iIN_VALID && (w_fill_nxt >= iLEN) && (w_diff == '0);
    assign oMATCH     = r_match;

    always_ff @(posedge iCLK) begin
        if (!iRST || iCLR) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_match <= 1'b0;
        end else begin
            r_match <= oHIT;
            if (iIN_VALID) begin
                r_hist <= w_hist_nxt;
                r_fill <= w_fill_nxt;
            end
        end
    end

endmodule

// File: rtl/logic_seq_ctrl.sv
// Run sequencer for the serial bit-pattern detector.
//   state | meaning
//   IDLE  | no valid configuration, iSTART ignored
//   ARMED | configuration held, waiting for iSTART
//   RUN   | accepting qualified bits, counting matches
//   DONE  | run finished (window end or abort), count held
// Ports: iCLK/iRST clock and sync active-low reset; iCFG_* / oCFG_READY
// config handshake, oCFG_ERR illegal-length pulse; iSTART/iABORT run
// control; iIN/iIN_VALID serial data; oMATCH pulse, oCOUNT match count,
// oBUSY (RUN), oDONE (DONE).
module logic_seq_ctrl
    import logic_seq_ctrl_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCFG_VALID,
    output logic               oCFG_READY,
    input  logic [MAX_LEN-1:0] iCFG_PATTERN,
    input  logic [LEN_W-1:0]   iCFG_LEN,
    input  logic [WIN_W-1:0]   iCFG_WINDOW,
    output logic               oCFG_ERR,
    input  logic               iSTART,
    input  logic               iABORT,
    input  logic               iIN,
    input  logic               iIN_VALID,
    output logic               oMATCH,
    output logic [CNT_W-1:0]   oCOUNT,
    output logic               oBUSY,
    output logic               oDONE
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [MAX_LEN-1:0] r_cfg_pattern;
    logic [LEN_W-1:0]   r_cfg_len;
    logic [WIN_W-1:0]   r_cfg_window;
    logic [WIN_W-1:0]   r_win_cnt;
    logic [CNT_W-1:0]   r_count;
    logic               r_cfg_err;

    logic               w_cfg_ready;
    logic               w_cfg_fire;
    logic               w_len_ok;
    logic               w_bit_acc;
    logic [WIN_W-1:0]   w_win_nxt;
    logic               w_win_end;
    logic               w_clr;
    logic               w_hit;

    assign w_cfg_ready = (r_state != ST_RUN);
    assign w_cfg_fire  = iCFG_VALID && w_cfg_ready;
    assign w_len_ok    = (iCFG_LEN != '0) && (iCFG_LEN <= LEN_W'(MAX_LEN));
    assign w_bit_acc   = (r_state == ST_RUN) && iIN_VALID;
    assign w_win_nxt   = r_win_cnt + WIN_W'(1);
    assign w_win_end   = w_bit_acc && (r_cfg_window != '0) && (w_win_nxt == r_cfg_window);

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cfg_fire && w_len_ok) w_state_nxt = ST_ARMED;
            end
            ST_ARMED, ST_DONE: begin
                // Any config offer takes priority over a simultaneous start.
                if (w_cfg_fire) begin
                    if (w_len_ok) w_state_nxt = ST_ARMED;
                end else if (iSTART) begin
                    w_state_nxt = ST_RUN;
                    w_clr       = 1'b1;
                end
            end
            ST_RUN: begin
                if (iABORT || w_win_end) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state       <= ST_IDLE;
            r_cfg_pattern <= '0;
            r_cfg_len     <= '0;
            r_cfg_window  <= '0;
            r_win_cnt     <= '0;
            r_count       <= '0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cfg_err <= w_cfg_fire && !w_len_ok;
            if (w_cfg_fire && w_len_ok) begin
                r_cfg_pattern <= iCFG_PATTERN;
                r_cfg_len     <= iCFG_LEN;
                r_cfg_window  <= iCFG_WINDOW;
            end
            if (w_clr) begin
                r_win_cnt <= '0;
                r_count   <= '0;
            end else begin
                if (w_bit_acc) r_win_cnt <= w_win_nxt;
                if (w_hit && (r_count != '1)) r_count <= r_count + CNT_W'(1);
            end
        end
    end

    logic_seq_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iCLR      (w_clr),
        .iIN       (iIN),
        .iIN_VALID (w_bit_acc),
        .iPATTERN  (r_cfg_pattern),
        .iLEN      (r_cfg_len),
        .oHIT      (w_hit),
        .oMATCH    (oMATCH)
    );

    assign oCFG_READY = w_cfg_ready;
    assign oCFG_ERR   = r_cfg_err;
    assign oCOUNT     = r_count;
    assign oBUSY      = (r_state == ST_RUN);
    assign oDONE      = (r_state == ST_DONE);

endmodule

// File: tb/tb_logic_seq_ctrl.sv
module tb_logic_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [15:0] cfg_window;
    logic        start, abort_r, din, din_valid;

    logic        rdy_a, err_a, match_a, busy_a, done_a;
    logic [7:0]  cnt_a;
    logic        rdy_b, err_b, match_b, busy_b, done_b;
    logic [1:0]  cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic_seq_ctrl #(.MAX_LEN(8), .LEN_W(4), .WIN_W(16), .CNT_W(8)) dut (
        .iCLK(clk), .iRST(rst), .iCFG_VALID(cfg_valid), .oCFG_READY(rdy_a),
        .iCFG_PATTERN(cfg_pattern), .iCFG_LEN(cfg_len), .iCFG_WINDOW(cfg_window),
        .oCFG_ERR(err_a), .iSTART(start), .iABORT(abort_r), .iIN(din),
        .iIN_VALID(din_valid), .oMATCH(match_a), .oCOUNT(cnt_a),
        .oBUSY(busy_a), .oDONE(done_a)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    logic_seq_ctrl #(.MAX_LEN(8), .LEN_W(4), .WIN_W(16), .CNT_W(2)) dut_sat (
        .iCLK(clk), .iRST(rst), .iCFG_VALID(cfg_valid), .oCFG_READY(rdy_b),
        .iCFG_PATTERN(cfg_pattern), .iCFG_LEN(cfg_len), .iCFG_WINDOW(cfg_window),
        .oCFG_ERR(err_b), .iSTART(start), .iABORT(abort_r), .iIN(din),
        .iIN_VALID(din_valid), .oMATCH(match_b), .oCOUNT(cnt_b),
        .oBUSY(busy_b), .oDONE(done_b)
    );

    typedef struct {
        logic        rst, cv;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [15:0] win;
        logic        st, ab, din, dv;
        logic        rdy, err, m;
        logic [7:0]  cnt;
        logic        busy, done;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(logic r, logic cv, logic [7:0] pat, logic [3:0] len,
                                logic [15:0] win, logic st, logic ab, logic d, logic dv,
                                logic rdy, logic err, logic m, logic [7:0] cnt,
                                logic busy, logic done);
        vec_t v;
        v.rst = r; v.cv = cv; v.pat = pat; v.len = len; v.win = win;
        v.st = st; v.ab = ab; v.din = d; v.dv = dv;
        v.rdy = rdy; v.err = err; v.m = m; v.cnt = cnt; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cv, input logic [7:0] pat,
                         input logic [3:0] len, input logic [15:0] win, input logic st,
                         input logic ab, input logic d, input logic dv);
        rst = r; cfg_valid = cv; cfg_pattern = pat; cfg_len = len; cfg_window = win;
        start = st; abort_r = ab; din = d; din_valid = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        rst = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_window = '0;
        start = 1'b0; abort_r = 1'b0; din = 1'b0; din_valid = 1'b0;

        //               rst cv pat len win st ab d dv | rdy err m cnt busy done
        vecs[0]  = mk(0, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0);
        // illegal lengths: error pulse, stay IDLE, start ignored
        vecs[1]  = mk(1, 1, 8'h0, 4'd0, 16'd0, 0, 0, 0, 0,  1, 1, 0, 8'd0, 0, 0);
        vecs[2]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0);
        vecs[3]  = mk(1, 1, 8'h0, 4'd9, 16'd0, 0, 0, 0, 0,  1, 1, 0, 8'd0, 0, 0);
        vecs[4]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0);
        // "101", window 5, stream 10101
        vecs[5]  = mk(1, 1, 8'h5, 4'd3, 16'd5, 0, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0);
        vecs[6]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[7]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[8]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[9]  = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd1, 1, 0);
        vecs[10] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 1,  0, 0, 0, 8'd1, 1, 0);
        vecs[11] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  1, 0, 1, 8'd2, 0, 1);
        vecs[12] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 0,  1, 0, 0, 8'd2, 0, 1);
        // restart from DONE; valid 1,0,1 with garbage gaps, then abort
        vecs[13] = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[14] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[15] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[16] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[17] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[18] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[19] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd1, 1, 0);
        vecs[20] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 0, 0,  0, 0, 0, 8'd1, 1, 0);
        vecs[21] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 1, 0, 0,  1, 0, 0, 8'd1, 0, 1);
        // "11", unbounded window, 1111 then abort, then restart
        vecs[22] = mk(1, 1, 8'h3, 4'd2, 16'd0, 0, 0, 0, 0,  1, 0, 0, 8'd1, 0, 0);
        vecs[23] = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0);
        vecs[24] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[25] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd1, 1, 0);
        vecs[26] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd2, 1, 0);
        vecs[27] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd3, 1, 0);
        vecs[28] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 1, 0, 0,  1, 0, 0, 8'd3, 0, 1);
        vecs[29] = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0);
        // two matches, then reset mid-run; start ignored afterwards
        vecs[30] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0);
        vecs[31] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd1, 1, 0);
        vecs[32] = mk(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  0, 0, 1, 8'd2, 1, 0);
        vecs[33] = mk(0, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1,  1, 0, 0, 8'd0, 0, 0);
        vecs[34] = mk(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < 35; i++) begin
            drive(vecs[i].rst, vecs[i].cv, vecs[i].pat, vecs[i].len, vecs[i].win,
                  vecs[i].st, vecs[i].ab, vecs[i].din, vecs[i].dv);
            check("cfg_ready", i, 32'(rdy_a),   32'(vecs[i].rdy));
            check("cfg_err",   i, 32'(err_a),   32'(vecs[i].err));
            check("match",     i, 32'(match_a), 32'(vecs[i].m));
            check("count",     i, 32'(cnt_a),   32'(vecs[i].cnt));
            check("busy",      i, 32'(busy_a),  32'(vecs[i].busy));
            check("done",      i, 32'(done_a),  32'(vecs[i].done));
        end

        // Saturation: pattern "1", six ones; last bit arrives with abort.
        drive(1, 1, 8'h1, 4'd1, 16'd0, 0, 0, 0, 0);
        drive(1, 0, 8'h0, 4'd0, 16'd0, 1, 0, 0, 0);
        check("sat_start_cnt", 100, 32'(cnt_b), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 8'h0, 4'd0, 16'd0, 0, (k == 5), 1, 1);
            if (match_b) pulses++;
            check("sat_match", 101 + k, 32'(match_b), 32'd1);
            check("sat_cnt2",  101 + k, 32'(cnt_b), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
            check("sat_cnt8",  101 + k, 32'(cnt_a), 32'(k + 1));
        end
        check("sat_done", 107, 32'(done_b), 32'd1);
        drive(1, 0, 8'h0, 4'd0, 16'd0, 0, 0, 1, 1);
        check("sat_quiet", 108, 32'(match_b), 32'd0);
        check("sat_hold",  108, 32'(cnt_b), 32'd3);
        check("sat_pulses", 109, 32'(pulses), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
